// File: rtl/axi_mem_slave.sv
// AXI4 memory slave: word-addressed 32-bit memory behind independent AXI
// write (AW/W/B) and read (AR/R) channels. FIXED and INCR bursts are always
// supported. WRAP bursts are supported only when AXI_WRAP_BURST_EN is defined;
// without it every WRAP beat returns SLVERR and writes nothing.
module axi_mem_slave #(
    parameter int          MEM_DEPTH = 256,
    parameter logic [31:0] ADDR_BASE = 32'h0000_0000
) (
    input  logic        aclk,
    input  logic        aresetn,
    // write address
    input  logic [3:0]  awid,
    input  logic [31:0] awaddr,
    input  logic [7:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    input  logic        awvalid,
    output logic        awready,
    // write data
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    // write response
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready,
    // read address
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [7:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    input  logic        arvalid,
    output logic        arready,
    // read data
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready
);

    localparam int IDX_W = $clog2(MEM_DEPTH);

`ifdef AXI_WRAP_BURST_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    logic [31:0] mem [MEM_DEPTH];

    // Word index relative to the base; addresses below the base wrap to huge
    // values and are therefore caught by the range check.
    function automatic logic [31:0] word_index(input logic [31:0] addr);
        return (addr - ADDR_BASE) >> 2;
    endfunction

    function automatic logic range_err(input logic [31:0] idx);
        return idx >= 32'(MEM_DEPTH);
    endfunction

    // Errors that hold for every beat of a burst, decided at the handshake.
    // An INCR burst errors as a whole if its last word lies in the next 4KB page.
    function automatic logic burst_err(input logic [11:0] page_off, input logic [7:0] len,
                                       input logic [2:0] size, input logic [1:0] burst);
        logic crosses;
        logic wrap_bad;
        crosses  = ({2'b00, page_off[11:2]} + {4'd0, len}) > 12'd1023;
        wrap_bad = !WRAP_EN || (page_off[1:0] != 2'b00) ||
                   !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
        return (size != 3'b010) || (burst == 2'b11) ||
               (burst == 2'b01 && crosses) || (burst == 2'b10 && wrap_bad);
    endfunction

    // Address of the following beat. For WRAP the window is (len+1)*4 bytes,
    // so the mask is len*4+3; illegal lengths error anyway, so no guard needed.
    function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [7:0] len,
                                              input logic [1:0] burst);
        logic [31:0] mask;
        mask = {22'd0, len, 2'b11};
        case (burst)
            2'b00:   return addr;
            2'b10:   return (addr & ~mask) | ((addr + 32'd4) & mask);
            default: return addr + 32'd4;
        endcase
    endfunction

    // ---------------- write channel ----------------
    w_state_t    w_state_reg;
    logic [3:0]  w_id_reg;
    logic [31:0] w_addr_reg;
    logic [7:0]  w_len_reg;
    logic [1:0]  w_burst_reg;
    logic        w_berr_reg;
    logic [7:0]  w_cnt_reg;
    logic        w_err_acc_reg;
    logic        awready_reg;
    logic        wready_reg;
    logic        bvalid_reg;
    logic [3:0]  bid_reg;
    logic [1:0]  bresp_reg;

    logic [31:0] w_idx;
    logic        w_fire;
    logic        w_last_beat;
    logic        w_beat_err;
    logic        mem_we;

    assign w_idx       = word_index(w_addr_reg);
    assign w_fire      = wready_reg && wvalid;
    assign w_last_beat = (w_cnt_reg == w_len_reg);
    assign w_beat_err  = w_berr_reg || range_err(w_idx) || (wlast != w_last_beat);
    assign mem_we      = w_fire && !w_beat_err;

    // Byte-lane memory write; erroring beats never reach the array.
    always_ff @(posedge aclk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) begin
                    mem[w_idx[IDX_W-1:0]][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    // Write FSM: accept address, consume awlen+1 beats, hold response until taken.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_state_reg   <= W_IDLE;
            w_id_reg      <= '0;
            w_addr_reg    <= '0;
            w_len_reg     <= '0;
            w_burst_reg   <= '0;
            w_berr_reg    <= 1'b0;
            w_cnt_reg     <= '0;
            w_err_acc_reg <= 1'b0;
            awready_reg   <= 1'b0;
            wready_reg    <= 1'b0;
            bvalid_reg    <= 1'b0;
            bid_reg       <= '0;
            bresp_reg     <= RESP_OKAY;
        end else begin
            case (w_state_reg)
                W_IDLE: begin
                    if (awready_reg && awvalid) begin
                        w_id_reg      <= awid;
                        w_addr_reg    <= awaddr;
                        w_len_reg     <= awlen;
                        w_burst_reg   <= awburst;
                        w_berr_reg    <= burst_err(awaddr[11:0], awlen, awsize, awburst);
                        w_cnt_reg     <= '0;
                        w_err_acc_reg <= 1'b0;
                        awready_reg   <= 1'b0;
                        wready_reg    <= 1'b1;
                        w_state_reg   <= W_DATA;
                    end else begin
                        awready_reg <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (w_fire) begin
                        w_cnt_reg     <= w_cnt_reg + 8'd1;
                        w_addr_reg    <= next_addr(w_addr_reg, w_len_reg, w_burst_reg);
                        w_err_acc_reg <= w_err_acc_reg || w_beat_err;
                        if (w_last_beat) begin
                            wready_reg  <= 1'b0;
                            bvalid_reg  <= 1'b1;
                            bid_reg     <= w_id_reg;
                            bresp_reg   <= (w_err_acc_reg || w_beat_err) ? RESP_SLVERR : RESP_OKAY;
                            w_state_reg <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        bvalid_reg  <= 1'b0;
                        awready_reg <= 1'b1;
                        w_state_reg <= W_IDLE;
                    end
                end
                default: w_state_reg <= W_IDLE;
            endcase
        end
    end

    // ---------------- read channel ----------------
    r_state_t    r_state_reg;
    logic [3:0]  rid_reg;
    logic [31:0] r_addr_reg;
    logic [7:0]  r_len_reg;
    logic [1:0]  r_burst_reg;
    logic        r_berr_reg;
    logic [7:0]  r_cnt_reg;
    logic        arready_reg;
    logic        rvalid_reg;
    logic        rlast_reg;
    logic [1:0]  rresp_reg;
    logic [31:0] rdata_reg;

    logic [31:0] ar_idx;
    logic        ar_berr;
    logic        ar_err;
    logic [31:0] r_next_addr;
    logic [31:0] r_next_idx;
    logic        r_next_err;
    logic        ar_fire;
    logic        r_advance;
    logic [31:0] rd_idx;
    logic        rd_err;

    assign ar_idx      = word_index(araddr);
    assign ar_berr     = burst_err(araddr[11:0], arlen, arsize, arburst);
    assign ar_err      = ar_berr || range_err(ar_idx);
    assign r_next_addr = next_addr(r_addr_reg, r_len_reg, r_burst_reg);
    assign r_next_idx  = word_index(r_next_addr);
    assign r_next_err  = r_berr_reg || range_err(r_next_idx);
    assign ar_fire     = (r_state_reg == R_IDLE) && arready_reg && arvalid;
    assign r_advance   = (r_state_reg == R_DATA) && rvalid_reg && rready && !rlast_reg;
    // One read port: the start word on the AR handshake, else the next beat's word.
    assign rd_idx      = ar_fire ? ar_idx : r_next_idx;
    assign rd_err      = ar_fire ? ar_err : r_next_err;

    // Read FSM: prefetch the next beat on each handshake so beats flow without bubbles.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state_reg <= R_IDLE;
            rid_reg     <= '0;
            r_addr_reg  <= '0;
            r_len_reg   <= '0;
            r_burst_reg <= '0;
            r_berr_reg  <= 1'b0;
            r_cnt_reg   <= '0;
            arready_reg <= 1'b0;
            rvalid_reg  <= 1'b0;
            rlast_reg   <= 1'b0;
            rresp_reg   <= RESP_OKAY;
            rdata_reg   <= '0;
        end else begin
            if (ar_fire || r_advance) begin
                rdata_reg <= rd_err ? 32'd0 : mem[rd_idx[IDX_W-1:0]];
                rresp_reg <= rd_err ? RESP_SLVERR : RESP_OKAY;
            end
            case (r_state_reg)
                R_IDLE: begin
                    if (ar_fire) begin
                        rid_reg     <= arid;
                        r_addr_reg  <= araddr;
                        r_len_reg   <= arlen;
                        r_burst_reg <= arburst;
                        r_berr_reg  <= ar_berr;
                        r_cnt_reg   <= '0;
                        arready_reg <= 1'b0;
                        rvalid_reg  <= 1'b1;
                        rlast_reg   <= (arlen == 8'd0);
                        r_state_reg <= R_DATA;
                    end else begin
                        arready_reg <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (rready) begin
                        if (rlast_reg) begin
                            rvalid_reg  <= 1'b0;
                            rlast_reg   <= 1'b0;
                            arready_reg <= 1'b1;
                            r_state_reg <= R_IDLE;
                        end else begin
                            r_addr_reg <= r_next_addr;
                            r_cnt_reg  <= r_cnt_reg + 8'd1;
                            rlast_reg  <= ((r_cnt_reg + 8'd1) == r_len_reg);
                        end
                    end
                end
                default: r_state_reg <= R_IDLE;
            endcase
        end
    end

    assign awready = awready_reg;
    assign wready  = wready_reg;
    assign bvalid  = bvalid_reg;
    assign bid     = bid_reg;
    assign bresp   = bresp_reg;
    assign arready = arready_reg;
    assign rvalid  = rvalid_reg;
    assign rlast   = rlast_reg;
    assign rid     = rid_reg;
    assign rresp   = rresp_reg;
    assign rdata   = rdata_reg;

endmodule

// File: tb/tb_axi_mem_slave.sv
// Directed bench for axi_mem_slave with a transaction-level memory model.
// Honours AXI_WRAP_BURST_EN the same way the design does.
module tb_axi_mem_slave;

    localparam int          DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic        aclk;
    logic        aresetn;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    axi_mem_slave #(.MEM_DEPTH(DEPTH), .ADDR_BASE(BASE)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: timed out waiting on DUT", name);
    endtask

    // ---------------- model ----------------
    typedef struct { logic [3:0] id; logic [31:0] data; logic [1:0] resp; logic last; } rbeat_t;
    typedef struct { logic [3:0] id; logic [1:0] resp; } bexp_t;

    logic [31:0] model_mem [DEPTH];
    rbeat_t      exp_r[$];
    bexp_t       exp_b[$];
    logic [31:0] got_r[$];
    logic [1:0]  got_rresp[$];
    logic [1:0]  got_b[$];
    logic [31:0] wd [16];
    logic [3:0]  ws [16];

    function automatic logic [31:0] m_addr(input logic [31:0] start, input int i, input int len,
                                           input logic [1:0] burst);
        longint unsigned s, sz, lo;
        s = start;
        if (burst == 2'b00) return start;
        if (burst == 2'b10) begin
            sz = longint'(len + 1) * 4;
            lo = s - (s % sz);
            return 32'(lo + ((s - lo + 4 * i) % sz));
        end
        return 32'(s + 4 * i);
    endfunction

    function automatic bit m_err(input logic [31:0] start, input logic [31:0] a, input int len,
                                 input logic [2:0] size, input logic [1:0] burst);
        logic [31:0]     diff;
        longint unsigned s;
        diff = a - BASE;
        s    = start;
        if ((diff >> 2) >= DEPTH) return 1'b1;
        if (size != 3'b010 || burst == 2'b11) return 1'b1;
        if (burst == 2'b01 && (((s / 4) * 4 + 4 * len) / 4096) != (s / 4096)) return 1'b1;
`ifdef AXI_WRAP_BURST_EN
        if (burst == 2'b10 && (!(len inside {1, 3, 7, 15}) || (s % 4) != 0)) return 1'b1;
`else
        if (burst == 2'b10) return 1'b1;
`endif
        return 1'b0;
    endfunction

    // Compare process: every valid beat/response is checked against the model queues.
    always @(negedge aclk) begin
        if (aresetn) begin
            if (rvalid) begin
                if (exp_r.size() == 0) begin
                    check("r_unexpected", {31'd0, rvalid}, 32'd0);
                end else begin
                    check("rid", {28'd0, rid}, {28'd0, exp_r[0].id});
                    check("rdata", rdata, exp_r[0].data);
                    check("rresp", {30'd0, rresp}, {30'd0, exp_r[0].resp});
                    check("rlast", {31'd0, rlast}, {31'd0, exp_r[0].last});
                    if (rready) begin
                        got_r.push_back(rdata);
                        got_rresp.push_back(rresp);
                        void'(exp_r.pop_front());
                    end
                end
            end
            if (bvalid) begin
                if (exp_b.size() == 0) begin
                    check("b_unexpected", {31'd0, bvalid}, 32'd0);
                end else begin
                    check("bid", {28'd0, bid}, {28'd0, exp_b[0].id});
                    check("bresp", {30'd0, bresp}, {30'd0, exp_b[0].resp});
                    if (bready) begin
                        got_b.push_back(bresp);
                        void'(exp_b.pop_front());
                    end
                end
            end
        end
    end

    // ---------------- transactions ----------------
    task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input int len,
                             input logic [2:0] size, input logic [1:0] burst,
                             input int bad_beat, input int bready_delay);
        bit          any_err;
        bit          e;
        logic [31:0] a;
        logic [31:0] idx;
        int          n;
        any_err = 1'b0;
        for (int i = 0; i <= len; i++) begin
            a = m_addr(addr, i, len, burst);
            e = m_err(addr, a, len, size, burst) || (i == bad_beat);
            if (!e) begin
                idx = (a - BASE) >> 2;
                for (int b = 0; b < 4; b++)
                    if (ws[i][b]) model_mem[idx][b*8 +: 8] = wd[i][b*8 +: 8];
            end
            any_err |= e;
        end
        exp_b.push_back('{id, any_err ? 2'b10 : 2'b00});

        @(posedge aclk); #1;
        awid = id; awaddr = addr; awlen = 8'(len); awsize = size; awburst = burst; awvalid = 1'b1;
        n = 0;
        @(negedge aclk);
        while (!awready && n < 50) begin n++; @(negedge aclk); end
        if (!awready) timeout_fail("awready");
        @(posedge aclk); #1;
        awvalid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            wvalid = 1'b1; wdata = wd[i]; wstrb = ws[i];
            wlast  = (i == len) ^ (i == bad_beat);
            n = 0;
            @(negedge aclk);
            while (!wready && n < 50) begin n++; @(negedge aclk); end
            if (!wready) timeout_fail("wready");
            @(posedge aclk); #1;
        end
        wvalid = 1'b0; wlast = 1'b0;
        for (int k = 0; k < bready_delay; k++) begin
            @(negedge aclk);
            check("bvalid_hold", {31'd0, bvalid}, 32'd1);
            check("awready_stall", {31'd0, awready}, 32'd0);
        end
        if (bready_delay > 0) begin @(posedge aclk); #1; end
        bready = 1'b1;
        n = 0;
        @(negedge aclk);
        while (!bvalid && n < 50) begin n++; @(negedge aclk); end
        if (!bvalid) timeout_fail("bvalid");
        @(posedge aclk); #1;
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input int len,
                            input logic [2:0] size, input logic [1:0] burst, input logic [3:0] pat);
        bit          e;
        bit          done;
        logic [31:0] a;
        int          n;
        for (int i = 0; i <= len; i++) begin
            a = m_addr(addr, i, len, burst);
            e = m_err(addr, a, len, size, burst);
            exp_r.push_back('{id, e ? 32'd0 : model_mem[(a - BASE) >> 2], e ? 2'b10 : 2'b00, i == len});
        end
        @(posedge aclk); #1;
        arid = id; araddr = addr; arlen = 8'(len); arsize = size; arburst = burst; arvalid = 1'b1;
        n = 0;
        @(negedge aclk);
        while (!arready && n < 50) begin n++; @(negedge aclk); end
        if (!arready) timeout_fail("arready");
        @(posedge aclk); #1;
        arvalid = 1'b0;
        done = 1'b0;
        n = 0;
        while (!done && n < 200) begin
            rready = pat[n % 4];
            @(negedge aclk);
            if (rvalid && rready && rlast) done = 1'b1;
            @(posedge aclk); #1;
            n++;
        end
        rready = 1'b0;
        if (!done) timeout_fail("rlast");
    endtask

    // Literal expectations on the accepted read beats (pins the model itself).
    task automatic pin_r(input string name, input int cnt, input logic [31:0] v0, input logic [31:0] v1,
                         input logic [31:0] v2, input logic [31:0] v3, input logic [1:0] resp);
        logic [31:0] v [4];
        v = '{v0, v1, v2, v3};
        check({name, "_beats"}, 32'(got_r.size()), 32'(cnt));
        for (int i = 0; i < cnt && i < got_r.size(); i++) begin
            check(name, got_r[i], v[i]);
            check({name, "_resp"}, {30'd0, got_rresp[i]}, {30'd0, resp});
        end
        $display("read  %s: %0d beats, first %h", name, got_r.size(), got_r.size() > 0 ? got_r[0] : 32'd0);
        got_r.delete();
        got_rresp.delete();
    endtask

    task automatic pin_b(input string name, input logic [1:0] resp);
        check({name, "_count"}, 32'(got_b.size()), 32'd1);
        if (got_b.size() > 0) check(name, {30'd0, got_b[0]}, {30'd0, resp});
        $display("write %s: bresp %b", name, got_b.size() > 0 ? got_b[0] : 2'bxx);
        got_b.delete();
    endtask

    task automatic set_w(input logic [31:0] base_val, input logic [3:0] strb);
        for (int i = 0; i < 16; i++) begin
            wd[i] = base_val + 32'(i);
            ws[i] = strb;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
        aresetn = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
        rready = 1'b0;

        // Reset state
        repeat (2) @(negedge aclk);
        check("rst_awready", {31'd0, awready}, 32'd0);
        check("rst_wready", {31'd0, wready}, 32'd0);
        check("rst_bvalid", {31'd0, bvalid}, 32'd0);
        check("rst_arready", {31'd0, arready}, 32'd0);
        check("rst_rvalid", {31'd0, rvalid}, 32'd0);
        check("rst_rlast", {31'd0, rlast}, 32'd0);
        check("rst_bid_bresp", {26'd0, bid, bresp}, 32'd0);
        check("rst_rid_rresp", {26'd0, rid, rresp}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        @(posedge aclk); #1;
        aresetn = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        check("rel_awready", {31'd0, awready}, 32'd1);
        check("rel_arready", {31'd0, arready}, 32'd1);

        // INCR write then read of four words
        set_w(32'd1, 4'hF);
        axi_write(4'd5, 32'h10, 3, 3'b010, 2'b01, -1, 0);
        pin_b("incr_w", 2'b00);
        axi_read(4'd9, 32'h10, 3, 3'b010, 2'b01, 4'b1111);
        pin_r("incr_r", 4, 32'd1, 32'd2, 32'd3, 32'd4, 2'b00);

        // Partial strobes
        wd[0] = 32'hAABBCCDD; ws[0] = 4'hF;
        axi_write(4'd1, 32'h0, 0, 3'b010, 2'b01, -1, 0);
        pin_b("full_w", 2'b00);
        wd[0] = 32'h11223344; ws[0] = 4'b0101;
        axi_write(4'd1, 32'h0, 0, 3'b010, 2'b01, -1, 0);
        pin_b("strb_w", 2'b00);
        axi_read(4'd2, 32'h0, 0, 3'b010, 2'b01, 4'b1111);
        pin_r("strb_r", 1, 32'hAA22CC44, 32'd0, 32'd0, 32'd0, 2'b00);

        // Out of range
        axi_read(4'd3, DEPTH * 4, 1, 3'b010, 2'b01, 4'b1111);
        pin_r("oor_r", 2, 32'd0, 32'd0, 32'd0, 32'd0, 2'b10);
        wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
        axi_write(4'd4, DEPTH * 4, 0, 3'b010, 2'b01, -1, 0);
        pin_b("oor_w", 2'b10);
        axi_read(4'd5, 32'h0, 0, 3'b010, 2'b01, 4'b1111);
        pin_r("oor_nochg", 1, 32'hAA22CC44, 32'd0, 32'd0, 32'd0, 2'b00);

        // Backpressure on R and B
        axi_read(4'd6, 32'h10, 3, 3'b010, 2'b01, 4'b1001);
        pin_r("stall_r", 4, 32'd1, 32'd2, 32'd3, 32'd4, 2'b00);
        wd[0] = 32'h55; ws[0] = 4'hF;
        axi_write(4'd7, 32'h20, 0, 3'b010, 2'b01, -1, 5);
        pin_b("stall_b", 2'b00);

        // WRAP burst over words 0..3
        set_w(32'hA0, 4'hF);
        axi_write(4'd2, 32'h0, 3, 3'b010, 2'b01, -1, 0);
        pin_b("wrap_pre", 2'b00);
        set_w(32'hB0, 4'hF);
        axi_write(4'd8, 32'h08, 3, 3'b010, 2'b10, -1, 0);
`ifdef AXI_WRAP_BURST_EN
        pin_b("wrap_w", 2'b00);
        axi_read(4'd3, 32'h0, 3, 3'b010, 2'b01, 4'b1111);
        pin_r("wrap_mem", 4, 32'hB2, 32'hB3, 32'hB0, 32'hB1, 2'b00);
        axi_read(4'd4, 32'h08, 3, 3'b010, 2'b10, 4'b1111);
        pin_r("wrap_r", 4, 32'hB0, 32'hB1, 32'hB2, 32'hB3, 2'b00);
`else
        pin_b("wrap_w", 2'b10);
        axi_read(4'd3, 32'h0, 3, 3'b010, 2'b01, 4'b1111);
        pin_r("wrap_mem", 4, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 2'b00);
        axi_read(4'd4, 32'h08, 3, 3'b010, 2'b10, 4'b1111);
        pin_r("wrap_r", 4, 32'd0, 32'd0, 32'd0, 32'd0, 2'b10);
`endif

        // wlast on the wrong beat: that beat errors and is dropped
        set_w(32'hD0, 4'hF);
        axi_write(4'd1, 32'h40, 1, 3'b010, 2'b01, -1, 0);
        pin_b("wl_pre", 2'b00);
        set_w(32'hC0, 4'hF);
        axi_write(4'd1, 32'h40, 1, 3'b010, 2'b01, 0, 0);
        pin_b("wl_bad", 2'b10);
        axi_read(4'd1, 32'h40, 1, 3'b010, 2'b01, 4'b1111);
        pin_r("wl_r", 2, 32'hD0, 32'hC1, 32'd0, 32'd0, 2'b00);

        // FIXED bursts, bad size, reserved burst
        axi_read(4'd2, 32'h10, 2, 3'b010, 2'b00, 4'b1111);
        pin_r("fixed_r", 3, 32'd1, 32'd1, 32'd1, 32'd0, 2'b00);
        set_w(32'd1, 4'hF);
        axi_write(4'd3, 32'h50, 2, 3'b010, 2'b00, -1, 0);
        pin_b("fixed_w", 2'b00);
        axi_read(4'd3, 32'h50, 0, 3'b010, 2'b01, 4'b1111);
        pin_r("fixed_wr", 1, 32'd3, 32'd0, 32'd0, 32'd0, 2'b00);
        axi_read(4'd4, 32'h10, 0, 3'b011, 2'b01, 4'b1111);
        pin_r("size_r", 1, 32'd0, 32'd0, 32'd0, 32'd0, 2'b10);
        set_w(32'h99, 4'hF);
        axi_write(4'd5, 32'h10, 0, 3'b010, 2'b11, -1, 0);
        pin_b("rsvd_w", 2'b10);

        // INCR crossing 4KB
        set_w(32'hE0, 4'hF);
        axi_write(4'd6, 32'hFF8, 1, 3'b010, 2'b01, -1, 0);
        pin_b("x4k_pre", 2'b00);
        set_w(32'hF0, 4'hF);
        axi_write(4'd6, 32'hFF8, 3, 3'b010, 2'b01, -1, 0);
        pin_b("x4k_w", 2'b10);
        axi_read(4'd6, 32'hFF8, 1, 3'b010, 2'b01, 4'b1111);
        pin_r("x4k_r", 2, 32'hE0, 32'hE1, 32'd0, 32'd0, 2'b00);

        // Reset in the middle of a write burst: first beat lands, no response
        @(posedge aclk); #1;
        awid = 4'd7; awaddr = 32'h60; awlen = 8'd3; awsize = 3'b010; awburst = 2'b01; awvalid = 1'b1;
        @(negedge aclk);
        check("mid_awready", {31'd0, awready}, 32'd1);
        @(posedge aclk); #1;
        awvalid = 1'b0;
        wvalid = 1'b1; wdata = 32'h77; wstrb = 4'hF; wlast = 1'b0;
        @(negedge aclk);
        check("mid_wready", {31'd0, wready}, 32'd1);
        @(posedge aclk); #1;
        wvalid = 1'b0;
        model_mem[32'h60 >> 2] = 32'h77;
        aresetn = 1'b0;
        @(negedge aclk);
        check("mid_rst_valids", {28'd0, bvalid, rvalid, wready, awready}, 32'd0);
        @(posedge aclk); #1;
        aresetn = 1'b1;
        wd[0] = 32'h88; ws[0] = 4'hF;
        axi_write(4'd8, 32'h64, 0, 3'b010, 2'b01, -1, 0);
        pin_b("post_rst_w", 2'b00);
        axi_read(4'd8, 32'h60, 1, 3'b010, 2'b01, 4'b1111);
        pin_r("post_rst_r", 2, 32'h77, 32'h88, 32'd0, 32'd0, 2'b00);

        repeat (3) @(posedge aclk);
        check("r_queue_drained", 32'(exp_r.size()), 32'd0);
        check("b_queue_drained", 32'(exp_b.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/axi_mem_slave.md
AXI_MEM_SLAVE -- requirements
Module: axi_mem_slave

Interface
REQ-001 Parameter MEM_DEPTH, default 256, number of 32-bit memory words (power of 2).
REQ-002 Parameter ADDR_BASE, default 32'h0000_0000, byte address of word 0.
REQ-003 Clock and reset SHALL be: reset aresetn, asynchronous, active-low; clock aclk.
REQ-004 aclk  in  1  system clock, all logic on rising edge.
REQ-005 aresetn  in  1  asynchronous active-low reset.
REQ-006 awid  in  4  write request ID.
REQ-007 awaddr  in  32  write start byte address.
REQ-008 awlen  in  8  write beats minus one.
REQ-009 awsize  in  3  write beat size; only 3'b010 legal.
REQ-010 awburst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved.
REQ-011 awvalid  in  1  write request valid.
REQ-012 awready  out  1  write request accepted.
REQ-013 wdata  in  32  write data.
REQ-014 wstrb  in  4  byte lane enables.
REQ-015 wlast  in  1  final write beat marker.
REQ-016 wvalid  in  1  write data valid.
REQ-017 wready  out  1  write data accepted.
REQ-018 bid  out  4  response ID, equals captured awid.
REQ-019 bresp  out  2  00 OKAY, 10 SLVERR.
REQ-020 bvalid  out  1  write response valid.
REQ-021 bready  in  1  master accepts response.
REQ-022 arid  in  4  read request ID.
REQ-023 araddr  in  32  read start byte address.
REQ-024 arlen  in  8  read beats minus one.
REQ-025 arsize  in  3  read beat size; only 3'b010 legal.
REQ-026 arburst  in  2  read burst type, encoding as awburst.
REQ-027 arvalid  in  1  read request valid.
REQ-028 arready  out  1  read request accepted.
REQ-029 rid  out  4  read ID, equals captured arid.
REQ-030 rdata  out  32  read data.
REQ-031 rresp  out  2  per-beat response, 00 OKAY, 10 SLVERR.
REQ-032 rlast  out  1  final read beat.
REQ-033 rvalid  out  1  read data valid.
REQ-034 rready  in  1  master accepts read beat.

Function
REQ-035 Write FSM W_IDLE->W_DATA->W_RESP->W_IDLE; awready=1 only in W_IDLE; on awvalid&&awready capture awid/awaddr/awlen/awsize/awburst and go to W_DATA next cycle.
REQ-036 W_DATA: wready=1; each wvalid&&wready writes the bytes enabled by wstrb at the current word on that edge; beat counter increments; the beat with count==awlen ends the burst -> W_RESP.
REQ-037 W_RESP: bvalid=1 with bid/bresp held stable until bvalid&&bready, then W_IDLE; awready returns to 1 the following cycle.
REQ-038 Read FSM R_IDLE->R_DATA->R_IDLE; arready=1 only in R_IDLE; rvalid rises the cycle after the arvalid&&arready handshake, with rdata registered from the start word.
REQ-039 R_DATA: rdata/rresp/rlast held stable while rvalid&&!rready; each handshake advances one beat with no bubble; rlast=1 when beat==arlen; the handshake on the last beat returns the FSM to R_IDLE.
REQ-040 Address: FIXED keeps the start address, INCR adds 4 per beat; word index = (addr-ADDR_BASE)>>2; the low 2 address bits are ignored.
REQ-041 SLVERR cases: word index >= MEM_DEPTH, awsize/arsize != 3'b010, burst 11, wlast value differing from (count==awlen), or an INCR crossing a 4KB boundary; erroring write beats SHALL NOT modify memory; erroring read beats return rdata=0.
REQ-042 bresp SHALL be SLVERR if any beat in the burst errored, else OKAY.
REQ-043 Read and write FSMs are independent and may run concurrently; a same-cycle read and write to one word returns the old data.

Reset
REQ-044 While aresetn=0: awready, wready, bvalid, arready, rvalid, rlast=0; bid, bresp, rid, rresp, rdata=0; both FSMs idle. Memory contents are not reset. Reset mid-burst aborts the burst with no response. Ready outputs assert on the first edge after release.

Configuration
REQ-045 Macro AXI_WRAP_BURST_EN defined: WRAP bursts are supported, with awlen/arlen restricted to 1, 3, 7 or 15, wrapping at the (len+1)*4-byte aligned boundary, and any other len or an unaligned start giving SLVERR. Macro undefined: every WRAP beat is SLVERR with no memory write.

Verification
REQ-046 INCR write awaddr=0x10, awlen=3, data 1..4, wstrb=F -> bresp=00, bid=awid; INCR read of the same -> rdata 1,2,3,4, rlast on beat 4 only.
REQ-047 Write 0xAABBCCDD to word 0, then wstrb=4'b0101 with 0x11223344 -> read returns 0xAA22CC44.
REQ-048 Read awaddr=MEM_DEPTH*4, arlen=1 -> two beats rresp=10, rdata=0; an out-of-range write -> bresp=10 and memory unchanged.
REQ-049 rready toggled 1,0,0,1 during a read burst -> rdata stable while stalled, no beat lost or duplicated; write with bready=0 for 5 cycles -> bvalid held, awready=0.
REQ-050 WRAP awaddr=0x08, awlen=3 -> beats at words 2,3,0,1 with macro defined; bresp=10 with no memory change without it; aresetn pulsed mid-burst -> all valids 0 and next request accepted.
